// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side resolution signals of the branch predictor.
// The master side drives addresses and updates; the slave side returns the prediction.
interface branch_predictor_if;
  logic [31:0] pc_in;
  logic [31:0] next_pc_out;
  logic        branch_taken_out;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  modport master (
    output pc_in, upd_valid, upd_pc, upd_taken, upd_target,
    input  next_pc_out, branch_taken_out
  );

  modport slave (
    input  pc_in, upd_valid, upd_pc, upd_taken, upd_target,
    output next_pc_out, branch_taken_out
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped, tagged branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational; one entry is written per cycle from EX resolution.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 10
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  branch_predictor_if.slave  bp
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_LO  = INDEX_BITS + 2;
  localparam int unsigned TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  logic                  r_valid  [ENTRIES];
  logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
  logic [1:0]            r_ctr    [ENTRIES];
  logic [31:0]           r_target [ENTRIES];

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0]   w_lk_tag;
  logic                  w_lk_hit;
  logic                  w_lk_taken;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [TAG_BITS-1:0]   w_upd_tag;
  logic                  w_upd_hit;
  logic                  w_we;
  logic [1:0]            w_ctr_next;
  logic [32-TAG_HI:0]    w_unused_lk_pc;
  logic [32-TAG_HI:0]    w_unused_upd_pc;

  // Address fields outside index/tag never participate in matching.
  assign w_unused_lk_pc  = {bp.pc_in[31:TAG_HI+1],  bp.pc_in[1:0]};
  assign w_unused_upd_pc = {bp.upd_pc[31:TAG_HI+1], bp.upd_pc[1:0]};

  // Zero-latency lookup: reads pre-update contents even when EX writes the same index.
  assign w_lk_idx   = bp.pc_in[INDEX_BITS+1:2];
  assign w_lk_tag   = bp.pc_in[TAG_HI:TAG_LO];
  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][1];

  assign bp.branch_taken_out = w_lk_taken;
  assign bp.next_pc_out      = w_lk_taken ? r_target[w_lk_idx] : bp.pc_in + 32'd4;

  assign w_upd_idx = bp.upd_pc[INDEX_BITS+1:2];
  assign w_upd_tag = bp.upd_pc[TAG_HI:TAG_LO];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_we      = rdy_in && !rst_in && bp.upd_valid;

  // Saturating counter step toward the resolved direction.
  always_comb begin
    w_ctr_next = r_ctr[w_upd_idx];
    if (bp.upd_taken) begin
      if (r_ctr[w_upd_idx] != 2'b11) w_ctr_next = r_ctr[w_upd_idx] + 2'd1;
    end else begin
      if (r_ctr[w_upd_idx] != 2'b00) w_ctr_next = r_ctr[w_upd_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (w_we) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= w_ctr_next;
      end else if (bp.upd_taken) begin
        r_valid[w_upd_idx] <= 1'b1;
        r_ctr[w_upd_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target carry no reset; a taken resolution always refreshes the target.
  always_ff @(posedge clk_in) begin
    if (w_we && bp.upd_taken) begin
      r_target[w_upd_idx] <= bp.upd_target;
      if (!w_upd_hit) r_tag[w_upd_idx] <= w_upd_tag;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a per-cycle reference model of the predictor table.
module tb_branch_predictor;

  localparam int unsigned IB = 6;
  localparam int unsigned TB = 10;
  localparam int unsigned NE = 1 << IB;

  logic clk;
  logic rst;
  logic rdy;
  branch_predictor_if bif ();

  branch_predictor #(.INDEX_BITS(IB), .TAG_BITS(TB)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bp     (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: plain per-index records with integer counters.
  bit          m_valid [NE];
  int unsigned m_tag   [NE];
  int          m_ctr   [NE];
  logic [31:0] m_tgt   [NE];
  bit          m_ready = 1'b0;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % NE;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc >> (IB + 2)) % (1 << TB);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NE); i++) begin
        m_valid[i] <= 1'b0;
        m_ctr[i]   <= 1;
      end
      m_ready <= 1'b1;
    end else if (rdy && bif.upd_valid) begin
      if (m_hit(bif.upd_pc)) begin
        if (bif.upd_taken) begin
          m_ctr[idx_of(bif.upd_pc)] <= (m_ctr[idx_of(bif.upd_pc)] >= 3) ? 3 : m_ctr[idx_of(bif.upd_pc)] + 1;
          m_tgt[idx_of(bif.upd_pc)] <= bif.upd_target;
        end else begin
          m_ctr[idx_of(bif.upd_pc)] <= (m_ctr[idx_of(bif.upd_pc)] <= 0) ? 0 : m_ctr[idx_of(bif.upd_pc)] - 1;
        end
      end else if (bif.upd_taken) begin
        m_valid[idx_of(bif.upd_pc)] <= 1'b1;
        m_tag[idx_of(bif.upd_pc)]   <= tag_of(bif.upd_pc);
        m_ctr[idx_of(bif.upd_pc)]   <= 2;
        m_tgt[idx_of(bif.upd_pc)]   <= bif.upd_target;
      end
    end
  end

  // Per-cycle comparison of both outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ready) begin
      logic        e_taken;
      logic [31:0] e_npc;
      e_taken = m_hit(bif.pc_in) && (m_ctr[idx_of(bif.pc_in)] >= 2);
      e_npc   = e_taken ? m_tgt[idx_of(bif.pc_in)] : bif.pc_in + 32'd4;
      check("cyc_taken", {31'd0, bif.branch_taken_out}, {31'd0, e_taken});
      check("cyc_next_pc", bif.next_pc_out, e_npc);
    end
  end

  task automatic drive(input logic r, input logic rd, input logic [31:0] pc,
                       input logic uv, input logic [31:0] up, input logic ut,
                       input logic [31:0] tg);
    @(posedge clk);
    #1;
    rst = r;
    rdy = rd;
    bif.pc_in      = pc;
    bif.upd_valid  = uv;
    bif.upd_pc     = up;
    bif.upd_taken  = ut;
    bif.upd_target = tg;
  endtask

  task automatic lit(input string name, input logic t, input logic [31:0] npc);
    #1;
    check({name, "_taken"}, {31'd0, bif.branch_taken_out}, {31'd0, t});
    check({name, "_npc"}, bif.next_pc_out, npc);
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b0;
    bif.pc_in      = 32'h0;
    bif.upd_valid  = 1'b1;
    bif.upd_pc     = 32'h1000;
    bif.upd_taken  = 1'b1;
    bif.upd_target = 32'h7000;
    // Reset cycles with a pending update, with and without ready.
    drive(1, 0, 32'h1000, 1, 32'h1000, 1, 32'h7000);
    drive(1, 1, 32'h1000, 1, 32'h1000, 1, 32'h7000);
    drive(0, 1, 32'h1000, 0, 32'h0, 0, 32'h0);
    lit("reset_miss", 1'b0, 32'h1004);

    // Allocate 0x1000 -> 0x2000; the same cycle still sees the miss.
    drive(0, 1, 32'h1000, 1, 32'h1000, 1, 32'h2000);
    lit("alloc_same_cycle", 1'b0, 32'h1004);
    drive(0, 1, 32'h1000, 0, 32'h0, 0, 32'h0);
    lit("alloc_hit", 1'b1, 32'h2000);
    check("model_ctr_alloc", 32'(m_ctr[idx_of(32'h1000)]), 32'd2);

    // Three not-taken (saturate at 0), then three taken (to 3, new target).
    drive(0, 1, 32'h1000, 1, 32'h1000, 0, 32'h0);
    drive(0, 1, 32'h1000, 1, 32'h1000, 0, 32'h0);
    lit("after_one_nt", 1'b0, 32'h1004);
    drive(0, 1, 32'h1000, 1, 32'h1000, 0, 32'h0);
    drive(0, 1, 32'h1000, 1, 32'h1000, 1, 32'h2000);
    check("model_ctr_floor", 32'(m_ctr[idx_of(32'h1000)]), 32'd0);
    drive(0, 1, 32'h1000, 1, 32'h1000, 1, 32'h2000);
    lit("ctr_one", 1'b0, 32'h1004);
    drive(0, 1, 32'h1000, 1, 32'h1000, 1, 32'h2400);
    lit("ctr_two", 1'b1, 32'h2000);
    drive(0, 1, 32'h1000, 0, 32'h0, 0, 32'h0);
    lit("ctr_three", 1'b1, 32'h2400);
    check("model_ctr_top", 32'(m_ctr[idx_of(32'h1000)]), 32'd3);
    drive(0, 1, 32'h1000, 1, 32'h1000, 1, 32'h2400);
    drive(0, 1, 32'h1000, 0, 32'h0, 0, 32'h0);
    lit("ctr_sat_top", 1'b1, 32'h2400);

    // Alias at the same index evicts the original occupant.
    drive(0, 1, 32'h1100, 1, 32'h1100, 1, 32'h3000);
    lit("alias_pre", 1'b0, 32'h1104);
    drive(0, 1, 32'h1000, 0, 32'h0, 0, 32'h0);
    lit("alias_evicted", 1'b0, 32'h1004);
    drive(0, 1, 32'h1100, 0, 32'h0, 0, 32'h0);
    lit("alias_hit", 1'b1, 32'h3000);

    // Ready low holds the table; outputs still follow pc, including wrap.
    drive(0, 0, 32'hFFFF_FFFC, 1, 32'h1000, 1, 32'h5000);
    lit("wrap_miss", 1'b0, 32'h0000_0000);
    drive(0, 0, 32'h1100, 1, 32'h1100, 0, 32'h0);
    lit("hold_alias", 1'b1, 32'h3000);
    drive(0, 0, 32'h1000, 1, 32'h1000, 1, 32'h5000);
    drive(0, 1, 32'h1000, 0, 32'h0, 0, 32'h0);
    lit("hold_no_alloc", 1'b0, 32'h1004);

    // Same-cycle lookup and update of one entry.
    drive(0, 1, 32'h1100, 1, 32'h1100, 0, 32'h0);
    lit("same_cycle_old", 1'b1, 32'h3000);
    drive(0, 1, 32'h1100, 0, 32'h0, 0, 32'h0);
    lit("same_cycle_new", 1'b0, 32'h1104);

    // Not-taken miss leaves the table alone.
    drive(0, 1, 32'h2040, 1, 32'h2040, 0, 32'h9000);
    drive(0, 1, 32'h2040, 1, 32'h2040, 1, 32'h9000);
    lit("nt_miss_nochange", 1'b0, 32'h2044);
    drive(0, 1, 32'h2040, 0, 32'h0, 0, 32'h0);
    lit("late_alloc", 1'b1, 32'h9000);

    // Reset during an update clears everything and drops the update.
    drive(1, 1, 32'h2040, 1, 32'h3000, 1, 32'h4000);
    drive(0, 1, 32'h2040, 0, 32'h0, 0, 32'h0);
    lit("rst_clear", 1'b0, 32'h2044);
    drive(0, 1, 32'h3000, 0, 32'h0, 0, 32'h0);
    lit("rst_drop_upd", 1'b0, 32'h3004);
    drive(0, 1, 32'h1100, 0, 32'h0, 0, 32'h0);
    lit("rst_clear_alias", 1'b0, 32'h1104);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter INDEX_BITS, default 6: table index width; the table has 2^INDEX_BITS entries.
REQ-002 Parameter TAG_BITS, default 10: stored tag width.
REQ-003 clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous and active-high.
REQ-005 rdy_in  input  1  global ready; when 0, all table state holds.
REQ-006 pc_in  input  32  fetch address to predict.
REQ-007 next_pc_out  output  32  predicted next fetch address, consumed by the PC register.
REQ-008 branch_taken_out  output  1  1 = prediction is taken.
REQ-009 upd_valid  input  1  EX resolved a control-transfer instruction this cycle.
REQ-010 upd_pc  input  32  address of the resolved instruction.
REQ-011 upd_taken  input  1  actual direction.
REQ-012 upd_target  input  32  actual taken target.

Function
REQ-013 Index shall be pc[INDEX_BITS+1:2]; tag shall be pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]; pc[1:0] shall be ignored.
REQ-014 Each entry shall hold: valid (1), tag (TAG_BITS), counter (2, saturating), target (32).
REQ-015 Lookup shall be combinational, zero latency: hit = valid && tag match at pc_in's index.
REQ-016 branch_taken_out shall be 1 iff hit and counter[1]==1.
REQ-017 next_pc_out shall be the entry target when branch_taken_out=1, else pc_in+4 with 32-bit wrap (0xFFFFFFFC -> 0x00000000).
REQ-018 Updates shall be written on a rising edge only when rdy_in=1, rst_in=0 and upd_valid=1.
REQ-019 Update hit (valid, tag matches upd_pc): the counter shall increment if upd_taken=1, else decrement, saturating at 3 and 0.
REQ-020 Update hit with upd_taken=1: the target shall be overwritten with upd_target.
REQ-021 Update miss with upd_taken=1: the entry shall be allocated (replacing any existing occupant) with valid=1, tag, target=upd_target and counter=2'b10.
REQ-022 Update miss with upd_taken=0: no state shall change.
REQ-023 Simultaneous lookup and update of the same index: the lookup shall return the pre-update contents; the new contents shall be visible from the next cycle.
REQ-024 When rdy_in=0, all table state shall hold; outputs still track pc_in combinationally.
REQ-025 Exactly one entry shall be modified per cycle at most.

Reset
REQ-026 A cycle with rst_in=1 shall clear all valid bits and set all counters to 2'b01, regardless of rdy_in or upd_valid.
REQ-027 After reset, every lookup shall miss: branch_taken_out=0 and next_pc_out=pc_in+4.
REQ-028 Reset asserted during an update cycle shall discard that update.
REQ-029 Target and tag contents need not be reset.

Verification
REQ-030 Reset, then pc_in=0x00001000 -> branch_taken_out=0, next_pc_out=0x00001004.
REQ-031 Update (pc 0x1000, taken, target 0x2000), then lookup 0x1000 -> taken=1, next_pc_out=0x2000, counter=2.
REQ-032 From counter=2, apply two not-taken updates, then three taken updates -> after the first not-taken update, taken=0 with next_pc_out=0x1004; after the second update the counter saturates at 0; after three taken updates the counter is 3 and taken=1.
REQ-033 Alias: allocate 0x1000 taken, then update 0x1000+(1<<(INDEX_BITS+2)) taken to target 0x3000 -> lookup 0x1000 misses; lookup of the alias address returns 0x3000.
REQ-034 Hold update with rdy_in=0 for 3 cycles -> no table change; lookup at pc_in=0xFFFFFFFC on a miss -> next_pc_out=0x00000000.
REQ-035 Same-cycle lookup and update of 0x1000 -> the old prediction is returned that cycle and the new one the following cycle.
